// File: rtl/conv_stream_scheduler.sv
// Two-requester scheduler for a shared conv accelerator: arbitrates whole request
// packets onto one stream and routes results back using an in-order tag FIFO.
module conv_stream_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
  input  logic                  s0_axis_tvalid,
  input  logic                  s0_axis_tlast,
  output logic                  s0_axis_tready,
  input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
  input  logic                  s1_axis_tvalid,
  input  logic                  s1_axis_tlast,
  output logic                  s1_axis_tready,
  output logic [DATA_WIDTH-1:0] acc_m_axis_tdata,
  output logic                  acc_m_axis_tvalid,
  output logic                  acc_m_axis_tlast,
  input  logic                  acc_m_axis_tready,
  input  logic [DATA_WIDTH-1:0] acc_s_axis_tdata,
  input  logic                  acc_s_axis_tvalid,
  input  logic                  acc_s_axis_tlast,
  output logic                  acc_s_axis_tready,
  output logic [DATA_WIDTH-1:0] m0_axis_tdata,
  output logic                  m0_axis_tvalid,
  output logic                  m0_axis_tlast,
  input  logic                  m0_axis_tready,
  output logic [DATA_WIDTH-1:0] m1_axis_tdata,
  output logic                  m1_axis_tvalid,
  output logic                  m1_axis_tlast,
  input  logic                  m1_axis_tready,
  output logic [1:0]            grant,
  output logic [15:0]           pkt_cnt0,
  output logic [15:0]           pkt_cnt1
);

  localparam int PW = $clog2(TAG_DEPTH);
  localparam logic [PW:0] DEPTH = (PW + 1)'(TAG_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD0 = 2'd1,
    FWD1 = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          last_served, last_served_nxt;
  logic          tag_mem [TAG_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          full, empty, head;
  logic          push, push_tag, pop;
  logic          done0, done1;

  assign full  = (count == DEPTH);
  assign empty = (count == '0);
  assign head  = tag_mem[rd_ptr];

  // A beat transfers on any cycle where tvalid and tready are both high; a packet
  // ends on the transfer carrying tlast.
  assign done0 = (state == FWD0) && s0_axis_tvalid && acc_m_axis_tready && s0_axis_tlast;
  assign done1 = (state == FWD1) && s1_axis_tvalid && acc_m_axis_tready && s1_axis_tlast;
  assign pop   = !empty && acc_s_axis_tvalid && acc_s_axis_tready && acc_s_axis_tlast;

  always_comb begin
    state_nxt       = state;
    last_served_nxt = last_served;
    push            = 1'b0;
    push_tag        = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the port that was not served last wins.
        if (!full) begin
          if (s0_axis_tvalid && (!s1_axis_tvalid || last_served)) begin
            state_nxt       = FWD0;
            last_served_nxt = 1'b0;
            push            = 1'b1;
            push_tag        = 1'b0;
          end else if (s1_axis_tvalid) begin
            state_nxt       = FWD1;
            last_served_nxt = 1'b1;
            push            = 1'b1;
            push_tag        = 1'b1;
          end
        end
      end
      FWD0:    if (done0) state_nxt = IDLE;
      FWD1:    if (done1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are forced quiet while rst is high, even before the reset edge lands.
  always_comb begin
    acc_m_axis_tdata  = '0;
    acc_m_axis_tvalid = 1'b0;
    acc_m_axis_tlast  = 1'b0;
    s0_axis_tready    = 1'b0;
    s1_axis_tready    = 1'b0;
    grant             = 2'b00;
    if (!rst) begin
      case (state)
        FWD0: begin
          acc_m_axis_tdata  = s0_axis_tdata;
          acc_m_axis_tvalid = s0_axis_tvalid;
          acc_m_axis_tlast  = s0_axis_tlast;
          s0_axis_tready    = acc_m_axis_tready;
          grant             = 2'b01;
        end
        FWD1: begin
          acc_m_axis_tdata  = s1_axis_tdata;
          acc_m_axis_tvalid = s1_axis_tvalid;
          acc_m_axis_tlast  = s1_axis_tlast;
          s1_axis_tready    = acc_m_axis_tready;
          grant             = 2'b10;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    m0_axis_tdata     = acc_s_axis_tdata;
    m1_axis_tdata     = acc_s_axis_tdata;
    m0_axis_tvalid    = 1'b0;
    m0_axis_tlast     = 1'b0;
    m1_axis_tvalid    = 1'b0;
    m1_axis_tlast     = 1'b0;
    acc_s_axis_tready = 1'b0;
    if (!rst && !empty) begin
      if (head) begin
        m1_axis_tvalid    = acc_s_axis_tvalid;
        m1_axis_tlast     = acc_s_axis_tlast;
        acc_s_axis_tready = m1_axis_tready;
      end else begin
        m0_axis_tvalid    = acc_s_axis_tvalid;
        m0_axis_tlast     = acc_s_axis_tlast;
        acc_s_axis_tready = m0_axis_tready;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_served <= 1'b1;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      pkt_cnt0    <= '0;
      pkt_cnt1    <= '0;
    end else begin
      state       <= state_nxt;
      last_served <= last_served_nxt;
      if (push) begin
        tag_mem[wr_ptr] <= push_tag;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (done0 && pkt_cnt0 != 16'hFFFF) pkt_cnt0 <= pkt_cnt0 + 16'd1;
      if (done1 && pkt_cnt1 != 16'hFFFF) pkt_cnt1 <= pkt_cnt1 + 16'd1;
    end
  end

endmodule

// File: tb/tb_conv_stream_scheduler.sv
// Bench for conv_stream_scheduler: queue-driven requesters/accelerator, packet-level
// reference model keyed on the origin bit carried in each request's first byte.
module tb_conv_stream_scheduler;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s0_axis_tdata, s1_axis_tdata, acc_m_axis_tdata, acc_s_axis_tdata;
  logic [DW-1:0] m0_axis_tdata, m1_axis_tdata;
  logic          s0_axis_tvalid, s0_axis_tlast, s0_axis_tready;
  logic          s1_axis_tvalid, s1_axis_tlast, s1_axis_tready;
  logic          acc_m_axis_tvalid, acc_m_axis_tlast, acc_m_axis_tready;
  logic          acc_s_axis_tvalid, acc_s_axis_tlast, acc_s_axis_tready;
  logic          m0_axis_tvalid, m0_axis_tlast, m0_axis_tready;
  logic          m1_axis_tvalid, m1_axis_tlast, m1_axis_tready;
  logic [1:0]    grant;
  logic [15:0]   pkt_cnt0, pkt_cnt1;

  always #5 clk = ~clk;

  conv_stream_scheduler #(.DATA_WIDTH(DW), .TAG_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .s0_axis_tdata(s0_axis_tdata), .s0_axis_tvalid(s0_axis_tvalid),
    .s0_axis_tlast(s0_axis_tlast), .s0_axis_tready(s0_axis_tready),
    .s1_axis_tdata(s1_axis_tdata), .s1_axis_tvalid(s1_axis_tvalid),
    .s1_axis_tlast(s1_axis_tlast), .s1_axis_tready(s1_axis_tready),
    .acc_m_axis_tdata(acc_m_axis_tdata), .acc_m_axis_tvalid(acc_m_axis_tvalid),
    .acc_m_axis_tlast(acc_m_axis_tlast), .acc_m_axis_tready(acc_m_axis_tready),
    .acc_s_axis_tdata(acc_s_axis_tdata), .acc_s_axis_tvalid(acc_s_axis_tvalid),
    .acc_s_axis_tlast(acc_s_axis_tlast), .acc_s_axis_tready(acc_s_axis_tready),
    .m0_axis_tdata(m0_axis_tdata), .m0_axis_tvalid(m0_axis_tvalid),
    .m0_axis_tlast(m0_axis_tlast), .m0_axis_tready(m0_axis_tready),
    .m1_axis_tdata(m1_axis_tdata), .m1_axis_tvalid(m1_axis_tvalid),
    .m1_axis_tlast(m1_axis_tlast), .m1_axis_tready(m1_axis_tready),
    .grant(grant), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int req_done = 0;

  // Beats are stored as {tlast, tdata}.
  logic [DW:0] s0_q[$], s1_q[$], as_q[$];
  logic [DW:0] am_obs[$], m0_obs[$], m1_obs[$];
  logic [DW:0] exp_req0[$], exp_req1[$], exp_m0[$], exp_m1[$];
  logic [1:0]  glog[$];
  logic        aslog[$];
  logic [10:0] ctl_snap;
  bit s0_en, s1_en, as_en, am_rdy, m0_rdy, m1_rdy, rnd, auto_resp, am_first;
  logic am_port;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    s0_axis_tvalid    = s0_en && (s0_q.size() > 0);
    s0_axis_tdata     = (s0_q.size() > 0) ? s0_q[0][DW-1:0] : '0;
    s0_axis_tlast     = (s0_q.size() > 0) ? s0_q[0][DW] : 1'b0;
    s1_axis_tvalid    = s1_en && (s1_q.size() > 0);
    s1_axis_tdata     = (s1_q.size() > 0) ? s1_q[0][DW-1:0] : '0;
    s1_axis_tlast     = (s1_q.size() > 0) ? s1_q[0][DW] : 1'b0;
    acc_s_axis_tvalid = as_en && (as_q.size() > 0);
    acc_s_axis_tdata  = (as_q.size() > 0) ? as_q[0][DW-1:0] : '0;
    acc_s_axis_tlast  = (as_q.size() > 0) ? as_q[0][DW] : 1'b0;
    acc_m_axis_tready = am_rdy;
    m0_axis_tready    = m0_rdy;
    m1_axis_tready    = m1_rdy;
  endtask

  task automatic clear_all();
    s0_q.delete(); s1_q.delete(); as_q.delete();
    am_obs.delete(); m0_obs.delete(); m1_obs.delete();
    exp_req0.delete(); exp_req1.delete(); exp_m0.delete(); exp_m1.delete();
    glog.delete(); aslog.delete();
  endtask

  // Request packet; the first byte's MSB names the originating port.
  task automatic make_pkt(int port, int len);
    logic [DW:0] b;
    for (int i = 0; i < len; i++) begin
      b[DW-1:0] = DW'($urandom);
      if (i == 0) b[DW-1] = port[0];
      b[DW] = (i == len - 1);
      if (port == 0) begin s0_q.push_back(b); exp_req0.push_back(b); end
      else begin s1_q.push_back(b); exp_req1.push_back(b); end
    end
  endtask

  task automatic gen_resp(logic port);
    int n;
    logic [DW:0] b;
    n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++) begin
      b = {(i == n - 1), DW'($urandom)};
      as_q.push_back(b);
      if (port) exp_m1.push_back(b); else exp_m0.push_back(b);
    end
  endtask

  // Runs from negedge+1 to the next negedge+1; observes 1ns before the rising edge.
  task automatic step();
    #3;
    glog.push_back(grant);
    aslog.push_back(acc_s_axis_tready);
    ctl_snap = {grant, s0_axis_tready, s1_axis_tready, acc_m_axis_tvalid, acc_m_axis_tlast,
                acc_s_axis_tready, m0_axis_tvalid, m0_axis_tlast, m1_axis_tvalid, m1_axis_tlast};
    if (s0_axis_tvalid && s0_axis_tready) void'(s0_q.pop_front());
    if (s1_axis_tvalid && s1_axis_tready) void'(s1_q.pop_front());
    if (acc_m_axis_tvalid && acc_m_axis_tready) begin
      am_obs.push_back({acc_m_axis_tlast, acc_m_axis_tdata});
      if (am_first) am_port = acc_m_axis_tdata[DW-1];
      am_first = acc_m_axis_tlast;
      if (acc_m_axis_tlast) begin
        req_done++;
        if (auto_resp) gen_resp(am_port);
      end
    end
    if (acc_s_axis_tvalid && acc_s_axis_tready) void'(as_q.pop_front());
    if (m0_axis_tvalid && m0_axis_tready) m0_obs.push_back({m0_axis_tlast, m0_axis_tdata});
    if (m1_axis_tvalid && m1_axis_tready) m1_obs.push_back({m1_axis_tlast, m1_axis_tdata});
    cyc++;
    @(negedge clk);
    if (rnd) begin
      s0_en  = ($urandom_range(0, 3) != 0);
      s1_en  = ($urandom_range(0, 3) != 0);
      as_en  = ($urandom_range(0, 3) != 0);
      am_rdy = ($urandom_range(0, 3) != 0);
      m0_rdy = ($urandom_range(0, 2) != 0);
      m1_rdy = ($urandom_range(0, 2) != 0);
    end
    drive();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_all();
    s0_q.push_back(9'h1A5); s1_q.push_back(9'h15A); as_q.push_back(9'h1C3);
    s0_en = 1; s1_en = 1; as_en = 1; am_rdy = 1; m0_rdy = 1; m1_rdy = 1;
    rnd = 0; auto_resp = 0;
    drive();
    repeat (2) begin
      step();
      check("reset_outputs", 32'(ctl_snap), 32'h0);
    end
    clear_all();
    rst = 1'b0;
    am_first = 1; req_done = 0; cyc = 0;
    drive();
    check("reset_pkt_cnt", {pkt_cnt1, pkt_cnt0}, 32'h0);
  endtask

  // Splits the accelerator request stream into packets and matches each against the
  // next expected packet of the port named by its first byte.
  task automatic check_req_stream(output int n0, output int n1, output int npk);
    int i0, i1, errs, pk;
    bit first;
    logic p;
    i0 = 0; i1 = 0; errs = 0; pk = 0; first = 1; p = 0;
    foreach (am_obs[k]) begin
      if (first) p = am_obs[k][DW-1];
      if (p) begin
        if (i1 >= exp_req1.size() || am_obs[k] !== exp_req1[i1]) errs++;
        i1++;
      end else begin
        if (i0 >= exp_req0.size() || am_obs[k] !== exp_req0[i0]) errs++;
        i0++;
      end
      first = am_obs[k][DW];
      if (first) pk++;
    end
    check("req_stream_errs", 32'(errs), 32'h0);
    n0 = i0; n1 = i1; npk = pk;
  endtask

  task automatic check_resp();
    int e0, e1;
    e0 = 0; e1 = 0;
    check("m0_beat_count", 32'(m0_obs.size()), 32'(exp_m0.size()));
    foreach (exp_m0[i]) if (i >= m0_obs.size() || m0_obs[i] !== exp_m0[i]) e0++;
    check("m0_data_errs", 32'(e0), 32'h0);
    check("m1_beat_count", 32'(m1_obs.size()), 32'(exp_m1.size()));
    foreach (exp_m1[i]) if (i >= m1_obs.size() || m1_obs[i] !== exp_m1[i]) e1++;
    check("m1_data_errs", 32'(e1), 32'h0);
  endtask

  initial begin
    int n0, n1, np, errs, sum, rises, waitc;
    int lens[3];
    logic [1:0] g;
    logic [DW:0] b;

    rst = 1'b1;
    s0_en = 0; s1_en = 0; as_en = 0; am_rdy = 0; m0_rdy = 0; m1_rdy = 0;
    rnd = 0; auto_resp = 0; am_first = 1; am_port = 0;
    drive();
    @(negedge clk);
    #1;
    do_reset();

    // Both ports loaded: expect 0,1,0 order with one idle cycle before each grant.
    make_pkt(0, 12); make_pkt(0, 12); make_pkt(1, 12);
    drive();
    repeat (45) step();
    errs = 0;
    for (int c = 0; c < 39; c++) begin
      g = (c % 13 == 0) ? 2'b00 : ((c / 13 == 1) ? 2'b10 : 2'b01);
      if (glog[c] !== g) errs++;
    end
    check("arb_grant_seq", 32'(errs), 32'h0);
    check_req_stream(n0, n1, np);
    check("arb_pkts", 32'(np), 32'd3);
    check("arb_beats", {16'(n1), 16'(n0)}, {16'd12, 16'd24});
    check("arb_pkt_cnt", {pkt_cnt1, pkt_cnt0}, {16'd1, 16'd2});

    // Port 0 alone, three back-to-back packets including a single-beat one.
    do_reset();
    lens[0] = 1; lens[1] = $urandom_range(2, 6); lens[2] = $urandom_range(2, 6);
    sum = 0;
    for (int i = 0; i < 3; i++) begin make_pkt(0, lens[i]); sum += lens[i]; end
    drive();
    repeat (sum + 8) step();
    errs = 0;
    begin
      int c;
      c = 0;
      for (int i = 0; i < 3; i++) begin
        if (glog[c] !== 2'b00) errs++;
        c++;
        for (int j = 0; j < lens[i]; j++) begin
          if (glog[c] !== 2'b01) errs++;
          c++;
        end
      end
      if (glog[c] !== 2'b00) errs++;
    end
    check("solo_grant_seq", 32'(errs), 32'h0);
    check_req_stream(n0, n1, np);
    check("solo_pkts", 32'(np), 32'd3);
    check("solo_beats", 32'(n0), 32'(sum));
    check("solo_pkt_cnt", {pkt_cnt1, pkt_cnt0}, {16'd0, 16'd3});

    // Tie on single-beat requests, then responses 0x11 and 0x22 routed by tag.
    do_reset();
    make_pkt(0, 1); make_pkt(1, 1);
    drive();
    repeat (6) step();
    check("route_pkt_cnt", {pkt_cnt1, pkt_cnt0}, {16'd1, 16'd1});
    b = {1'b1, 8'h11}; as_q.push_back(b); exp_m0.push_back(b);
    b = {1'b1, 8'h22}; as_q.push_back(b); exp_m1.push_back(b);
    drive();
    repeat (4) step();
    check_resp();

    // Accelerator silent: tag FIFO fills after four grants, one pop frees a slot.
    do_reset();
    as_en = 0;
    for (int i = 0; i < 3; i++) begin make_pkt(0, 2); make_pkt(1, 2); end
    drive();
    repeat (40) step();
    rises = 0;
    for (int c = 1; c < glog.size(); c++) if (glog[c] != 2'b00 && glog[c-1] == 2'b00) rises++;
    check("full_grants", 32'(rises), 32'd4);
    check("full_idle_ready", {grant, s0_axis_tready, s1_axis_tready}, 32'h0);
    check_req_stream(n0, n1, np);
    check("full_pkts", 32'(np), 32'd4);
    b = {1'b1, 8'h5E}; as_q.push_back(b); exp_m0.push_back(b);
    as_en = 1;
    drive();
    step();
    check("full_pop_ready", 32'(aslog[aslog.size()-1]), 32'd1);
    waitc = 0;
    do begin
      step();
      waitc++;
    end while (glog[glog.size()-1] == 2'b00 && waitc < 6);
    check("fifth_grant_latency", 32'(waitc <= 2), 32'd1);
    check("fifth_grant_port", 32'(glog[glog.size()-1]), 32'd1);
    check_resp();

    // m0 stalls five cycles mid-response.
    do_reset();
    make_pkt(0, 1);
    drive();
    repeat (4) step();
    for (int i = 0; i < 4; i++) begin
      b = {(i == 3), DW'($urandom)};
      as_q.push_back(b); exp_m0.push_back(b);
    end
    drive();
    step();
    m0_rdy = 0;
    drive();
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_acc_s_ready", 32'(aslog[aslog.size()-1]), 32'd0);
    end
    m0_rdy = 1;
    drive();
    repeat (6) step();
    check_resp();

    // Reset in the middle of a port-1 packet, then a normal port-0 packet.
    do_reset();
    make_pkt(1, 10);
    drive();
    waitc = 0;
    while (am_obs.size() < 5 && waitc < 30) begin
      step();
      waitc++;
    end
    check("rst_mid_beats", 32'(am_obs.size()), 32'd5);
    do_reset();
    check("rst_fifo_empty", {acc_s_axis_tready, grant}, 32'h0);
    auto_resp = 1;
    make_pkt(0, 3);
    drive();
    repeat (14) step();
    check_req_stream(n0, n1, np);
    check("rst_next_pkts", 32'(np), 32'd1);
    check("rst_next_cnt", {pkt_cnt1, pkt_cnt0}, {16'd0, 16'd1});
    check_resp();

    // Random traffic, random back-pressure on every port.
    do_reset();
    rnd = 1; auto_resp = 1;
    for (int i = 0; i < 8; i++) begin
      make_pkt(0, $urandom_range(1, 6));
      make_pkt(1, $urandom_range(1, 6));
    end
    drive();
    while (!(s0_q.size() == 0 && s1_q.size() == 0 && as_q.size() == 0 && req_done == 16)
           && cyc < 4000) step();
    check("rand_completed", 32'(req_done == 16 && as_q.size() == 0), 32'd1);
    rnd = 0; m0_rdy = 1; m1_rdy = 1;
    drive();
    repeat (3) step();
    check_req_stream(n0, n1, np);
    check("rand_pkts", 32'(np), 32'd16);
    check("rand_beats", {16'(n1), 16'(n0)}, {16'(exp_req1.size()), 16'(exp_req0.size())});
    check("rand_pkt_cnt", {pkt_cnt1, pkt_cnt0}, {16'd8, 16'd8});
    check_resp();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
